// File: rtl/wb_stage.sv
// Writeback stage: registers the MEM result, formats big-endian load data,
// drives the register file write port, flags misaligned loads and counts
// retired instructions.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              mem_valid_i,
  input  logic              mem_wreg_i,
  input  logic [ADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [2:0]        mem_ld_op_i,
  input  logic [1:0]        mem_addr_lo_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              exc_align_o,
  output logic [31:0]       instret_o
);

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LB   = 3'b001,
    LD_LBU  = 3'b010,
    LD_LH   = 3'b011,
    LD_LHU  = 3'b100,
    LD_LW   = 3'b101
  } ld_op_e;

  logic              wreg_q, wreg_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              exc_q, exc_d;
  logic [31:0]       instret_q, instret_d;

  logic              cap;
  logic              misaligned;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] fmt_data;

  // Load formatting and misalignment detection (big-endian: offset 0 is MSB)
  always_comb begin
    ld_byte    = 8'h00;
    ld_half    = 16'h0000;
    fmt_data   = mem_wdata_i;
    misaligned = 1'b0;
    case (mem_addr_lo_i)
      2'd0:    ld_byte = mem_rdata_i[31:24];
      2'd1:    ld_byte = mem_rdata_i[23:16];
      2'd2:    ld_byte = mem_rdata_i[15:8];
      default: ld_byte = mem_rdata_i[7:0];
    endcase
    ld_half = mem_addr_lo_i[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
    case (mem_ld_op_i)
      LD_LB:  fmt_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU: fmt_data = {24'h000000, ld_byte};
      LD_LH: begin
        fmt_data   = {{16{ld_half[15]}}, ld_half};
        misaligned = mem_addr_lo_i[0];
      end
      LD_LHU: begin
        fmt_data   = {16'h0000, ld_half};
        misaligned = mem_addr_lo_i[0];
      end
      LD_LW: begin
        fmt_data   = mem_rdata_i;
        misaligned = (mem_addr_lo_i != 2'd0);
      end
      default: fmt_data = mem_wdata_i;
    endcase
  end

  // Next-state: bubble on flush/stall/invalid, else capture the instruction
  always_comb begin
    cap       = mem_valid_i & ~stall_i & ~flush_i;
    wreg_d    = 1'b0;
    waddr_d   = '0;
    wdata_d   = '0;
    exc_d     = 1'b0;
    instret_d = instret_q;
    if (cap) begin
      wreg_d    = mem_wreg_i & (mem_wd_i != '0) & ~misaligned;
      waddr_d   = mem_wd_i;
      wdata_d   = fmt_data;
      exc_d     = misaligned;
      instret_d = instret_q + 32'd1;
    end
  end

  // WB pipeline register and retired-instruction counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wreg_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      exc_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      wreg_q    <= wreg_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      exc_q     <= exc_d;
      instret_q <= instret_d;
    end
  end

  assign we_o        = wreg_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign exc_align_o = exc_q;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, load formatting, r0/misaligned
// suppression, stall/flush bubbles, streaming, counter wrap, async reset.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, mem_valid_i, mem_wreg_i;
  logic [4:0]  mem_wd_i;
  logic [31:0] mem_wdata_i;
  logic [2:0]  mem_ld_op_i;
  logic [1:0]  mem_addr_lo_i;
  logic [31:0] mem_rdata_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        exc_align_o;
  logic [31:0] instret_o;

  int checks = 0;
  int errors = 0;

  wb_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .mem_valid_i(mem_valid_i), .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
    .mem_wdata_i(mem_wdata_i), .mem_ld_op_i(mem_ld_op_i),
    .mem_addr_lo_i(mem_addr_lo_i), .mem_rdata_i(mem_rdata_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .exc_align_o(exc_align_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one MEM-stage slot, then sample 1 time unit after the capturing edge
  task automatic step(input logic v, input logic wr, input logic [4:0] wd,
                      input logic [31:0] wdat, input logic [2:0] op,
                      input logic [1:0] lo, input logic st, input logic fl);
    mem_valid_i   = v;
    mem_wreg_i    = wr;
    mem_wd_i      = wd;
    mem_wdata_i   = wdat;
    mem_ld_op_i   = op;
    mem_addr_lo_i = lo;
    stall_i       = st;
    flush_i       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic ex, input logic [31:0] cnt);
    check({tag, ".we"}, {31'd0, we_o}, {31'd0, we});
    check({tag, ".waddr"}, {27'd0, waddr_o}, {27'd0, wa});
    check({tag, ".wdata"}, wdata_o, wd);
    check({tag, ".exc"}, {31'd0, exc_align_o}, {31'd0, ex});
    check({tag, ".instret"}, instret_o, cnt);
  endtask

  localparam logic [31:0] RD = 32'h80F17F02;

  initial begin
    rst = 1'b0;
    mem_rdata_i = RD;
    // Reset held with valid traffic: outputs stay zero
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 5'd3 + 5'(i), 32'hA5A5A5A5, 3'b000, 2'd0, 1'b0, 1'b0);
      outs($sformatf("reset%0d", i), 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    step(1'b1, 1'b1, 5'd3, 32'h12345678, 3'b000, 2'd0, 1'b0, 1'b0);
    outs("add_r3", 1'b1, 5'd3, 32'h12345678, 1'b0, 32'd1);

    // Load formatting, all to r7
    step(1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 3'b001, 2'd0, 1'b0, 1'b0);
    outs("lb_off0", 1'b1, 5'd7, 32'hFFFFFF80, 1'b0, 32'd2);
    step(1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 3'b010, 2'd0, 1'b0, 1'b0);
    outs("lbu_off0", 1'b1, 5'd7, 32'h00000080, 1'b0, 32'd3);
    step(1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 3'b001, 2'd2, 1'b0, 1'b0);
    outs("lb_off2", 1'b1, 5'd7, 32'h0000007F, 1'b0, 32'd4);
    step(1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 3'b011, 2'd2, 1'b0, 1'b0);
    outs("lh_off2", 1'b1, 5'd7, 32'h00007F02, 1'b0, 32'd5);
    step(1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 3'b100, 2'd0, 1'b0, 1'b0);
    outs("lhu_off0", 1'b1, 5'd7, 32'h000080F1, 1'b0, 32'd6);
    step(1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 3'b101, 2'd0, 1'b0, 1'b0);
    outs("lw", 1'b1, 5'd7, 32'h80F17F02, 1'b0, 32'd7);
    step(1'b1, 1'b1, 5'd7, 32'h0BADF00D, 3'b110, 2'd1, 1'b0, 1'b0);
    outs("ldop110", 1'b1, 5'd7, 32'h0BADF00D, 1'b0, 32'd8);
    step(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 3'b001, 2'd3, 1'b0, 1'b0);
    outs("lb_off3", 1'b1, 5'd8, 32'h00000002, 1'b0, 32'd9);

    // r0 and misaligned loads
    step(1'b1, 1'b1, 5'd0, 32'h11111111, 3'b000, 2'd0, 1'b0, 1'b0);
    outs("r0", 1'b0, 5'd0, 32'h11111111, 1'b0, 32'd10);
    step(1'b1, 1'b1, 5'd5, 32'h0, 3'b101, 2'd2, 1'b0, 1'b0);
    outs("lw_mis", 1'b0, 5'd5, 32'h80F17F02, 1'b1, 32'd11);
    step(1'b0, 1'b0, 5'd0, 32'h0, 3'b000, 2'd0, 1'b0, 1'b0);
    outs("bubble", 1'b0, 5'd0, 32'h0, 1'b0, 32'd11);
    step(1'b1, 1'b1, 5'd6, 32'h0, 3'b011, 2'd1, 1'b0, 1'b0);
    outs("lh_mis", 1'b0, 5'd6, 32'hFFFF80F1, 1'b1, 32'd12);

    // Stall / flush bubbles
    step(1'b1, 1'b1, 5'd4, 32'h22222222, 3'b000, 2'd0, 1'b1, 1'b0);
    outs("stall", 1'b0, 5'd0, 32'h0, 1'b0, 32'd12);
    step(1'b1, 1'b1, 5'd5, 32'h0, 3'b101, 2'd2, 1'b0, 1'b1);
    outs("flush_mis", 1'b0, 5'd0, 32'h0, 1'b0, 32'd12);
    step(1'b1, 1'b1, 5'd4, 32'h33333333, 3'b000, 2'd0, 1'b1, 1'b1);
    outs("stall_flush", 1'b0, 5'd0, 32'h0, 1'b0, 32'd12);

    // Streaming r1..r4
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 5'(i), 32'h11 * i, 3'b000, 2'd0, 1'b0, 1'b0);
      outs($sformatf("stream%0d", i), 1'b1, 5'(i), 32'h11 * i, 1'b0, 32'(12 + i));
    end

    // Asynchronous reset mid-stream clears immediately
    step(1'b1, 1'b1, 5'd9, 32'h99999999, 3'b101, 2'd1, 1'b0, 1'b0);
    outs("pre_arst", 1'b0, 5'd9, 32'h80F17F02, 1'b1, 32'd17);
    #2;
    rst = 1'b0;
    #1;
    outs("arst", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Counter wrap via preload of the counter flop
    @(negedge clk);
    force dut.instret_q = 32'hFFFFFFFE;
    #1;
    release dut.instret_q;
    step(1'b1, 1'b1, 5'd10, 32'hAAAA0000, 3'b000, 2'd0, 1'b0, 1'b0);
    outs("wrap_max", 1'b1, 5'd10, 32'hAAAA0000, 1'b0, 32'hFFFFFFFF);
    step(1'b1, 1'b1, 5'd11, 32'hBBBB0000, 3'b000, 2'd0, 1'b0, 1'b0);
    outs("wrap_zero", 1'b1, 5'd11, 32'hBBBB0000, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage MIPS pipeline. Registers the MEM-stage result and formats load data (byte/half extraction, sign or zero extension, big-endian). Drives the register file write port (we/waddr/wdata) one cycle after MEM, suppresses writes to r0 and misaligned loads, raises an alignment exception and keeps a retired-instruction counter.

## Interface
- DATA_W, 32, datapath width; byte/half extraction requires exactly 32
- ADDR_W, 5, register address width
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- stall_i  in  1  MEM stalled while WB proceeds: capture a bubble
- flush_i  in  1  exception flush: capture a bubble; wins over all other inputs
- mem_valid_i  in  1  MEM holds a real instruction
- mem_wreg_i  in  1  instruction writes a GPR
- mem_wd_i  in  ADDR_W  destination register
- mem_wdata_i  in  DATA_W  ALU/move result (non-load)
- mem_ld_op_i  in  3  000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; 110/111 treated as none
- mem_addr_lo_i  in  2  effective address bits [1:0]
- mem_rdata_i  in  DATA_W  raw aligned memory word
- we_o  out  1  register file write enable
- waddr_o  out  ADDR_W  register file write address
- wdata_o  out  DATA_W  register file write data
- exc_align_o  out  1  one-cycle pulse: misaligned load retired
- instret_o  out  32  retired-instruction count

## Operation
- Capture at each rising edge: if flush_i or stall_i or !mem_valid_i → bubble (valid_q=0, wreg_q=0, waddr_q=0, wdata_q=0); else capture instruction.
- Load formatting, big-endian (offset 0 = bits 31:24):
  - LB/LBU: byte at offset addr_lo; LB sign-extends bit 7, LBU zero-extends.
  - LH/LHU: offset 0 → bits 31:16, offset 2 → bits 15:0; LH sign, LHU zero.
  - LW: full word.
  - none: wdata = mem_wdata_i.
- Misalignment: LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0 → write suppressed (wreg_q=0), exc_align_q=1 for that cycle, instret still increments.
- we_o = wreg_q; wreg_q captured as mem_wreg_i & mem_wd_i≠0 & !misaligned. With we_o=0, waddr_o/wdata_o still reflect the captured values (not forced to 0) except for bubbles.
- instret_o increments by 1 for each captured valid instruction (bubbles excluded); wraps 0xFFFFFFFF → 0 silently.
- exc_align_o high for exactly the cycle the offending instruction occupies WB; low after bubbles.

## Timing
- Reset (rst=0, asynchronous): we_o=0, waddr_o=0, wdata_o=0, exc_align_o=0, instret_o=0; held while rst=0. First capture on first rising edge after deassertion.
- Latency: MEM inputs at edge N → outputs valid after edge N, i.e. write committed into the register file at edge N+1. Register file read-after-write bypass covers the same-cycle ID read.
- All outputs registered; no combinational path from inputs to outputs.
- Back-to-back instructions: one per cycle, no bubbles inserted by this block.
- flush_i and stall_i together → bubble; flush_i with misaligned load → no exception pulse, no count.
- Reset mid-operation: in-flight WB instruction discarded, counter cleared.

## Test plan
- Reset: hold rst=0 with valid inputs toggling → all outputs 0; release, ADD r3=0x12345678 → next cycle we_o=1, waddr_o=3, wdata_o=0x12345678, instret_o=1.
- Loads, rdata=0x80F17F02: LB off0 → 0xFFFFFF80; LBU off0 → 0x00000080; LB off2 → 0x0000007F; LH off2 → 0x00007F02; LHU off0 → 0x000080F1; LW → 0x80F17F02.
- r0 and misaligned: write to r0 → we_o=0, instret +1; LW addr_lo=2 to r5 → we_o=0, exc_align_o=1 one cycle, instret +1; LH addr_lo=1 → same.
- Stall/flush: valid ADD with stall_i=1 → bubble (we_o=0, count unchanged); same with flush_i=1 and misaligned LW → no exception, no count.
- Streaming: 4 consecutive valid writes r1..r4 → we_o=1 for 4 cycles, addresses 1,2,3,4 in order, instret 1..4.
- Counter wrap: preload via 2^32-1 retirements (or force) → next retirement gives instret_o=0; asynchronous reset asserted mid-stream clears outputs immediately, not at a clock edge.
